// File: rtl/mxu_pkg.sv
// Shared types and default geometry for the MXU operand loader.
package mxu_pkg;

  localparam int unsigned MXU_DIM   = 4;
  localparam int unsigned MXU_WIDTH = 8;

  typedef logic [MXU_DIM-1:0][MXU_DIM-1:0][MXU_WIDTH-1:0] matrix_in_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/mxu_watchdog.sv
// Clearable up-counter; expired flags the last allowed WAIT cycle.
module mxu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mxu_operand_loader.sv
// Assembles A then B (row-major) from an element stream, issues them to the
// multiplier and holds them until finished or the watchdog expires.
module mxu_operand_loader
  import mxu_pkg::*;
#(
  parameter int unsigned DIM            = MXU_DIM,
  parameter int unsigned WIDTH          = MXU_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [WIDTH-1:0]                     elem_in,
  input  logic                                 elem_valid,
  output logic                                 elem_ready,
  output logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   mxu_in0,
  output logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   mxu_in1,
  output logic                                 mxu_in_valid,
  input  logic                                 mxu_finished,
  output logic                                 busy,
  output logic                                 timeout_err,
  input  logic                                 err_clear,
  output logic [15:0]                          job_count
);

  localparam int unsigned DD    = DIM * DIM;
  localparam int unsigned NELEM = 2 * DD;
  localparam int unsigned IW    = $clog2(NELEM);

  state_t        state;
  logic [IW-1:0] idx;
  logic          hs;
  logic          wd_clr;
  logic          wd_en;
  logic          wd_expired;

  assign hs     = elem_valid && elem_ready;
  assign wd_clr = (state == ISSUE);
  assign wd_en  = (state == WAIT) && !mxu_finished && !wd_expired;

  mxu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // elem_ready and busy are registered copies of the next state's decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= LOAD;
      idx          <= '0;
      mxu_in0      <= '0;
      mxu_in1      <= '0;
      mxu_in_valid <= 1'b0;
      elem_ready   <= 1'b1;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      job_count    <= '0;
    end else begin
      mxu_in_valid <= 1'b0;
      if (err_clear) begin
        timeout_err <= 1'b0;
      end
      case (state)
        LOAD: begin
          if (hs) begin
            for (int unsigned r = 0; r < DIM; r++) begin
              for (int unsigned c = 0; c < DIM; c++) begin
                if (idx == IW'(r * DIM + c)) begin
                  mxu_in0[r][c] <= elem_in;
                end
                if (idx == IW'(DD + r * DIM + c)) begin
                  mxu_in1[r][c] <= elem_in;
                end
              end
            end
            if (idx == IW'(NELEM - 1)) begin
              idx          <= '0;
              state        <= ISSUE;
              mxu_in_valid <= 1'b1;
              elem_ready   <= 1'b0;
              busy         <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // A finish on the final watchdog cycle wins over the timeout.
          if (mxu_finished) begin
            job_count  <= job_count + 16'd1;
            state      <= LOAD;
            elem_ready <= 1'b1;
            busy       <= 1'b0;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            state       <= LOAD;
            elem_ready  <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: begin
          state      <= LOAD;
          elem_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mxu_operand_loader.sv
// Directed bench for mxu_operand_loader with a fixed-latency mock multiplier.
module tb_mxu_operand_loader;

  localparam int unsigned DIM   = 2;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned TO    = 16;

  logic                               clk = 1'b0;
  logic                               reset_n = 1'b0;
  logic [WIDTH-1:0]                   elem_in = '0;
  logic                               elem_valid = 1'b0;
  logic                               elem_ready;
  logic [DIM-1:0][DIM-1:0][WIDTH-1:0] mxu_in0;
  logic [DIM-1:0][DIM-1:0][WIDTH-1:0] mxu_in1;
  logic                               mxu_in_valid;
  logic                               mxu_finished;
  logic                               busy;
  logic                               timeout_err;
  logic                               err_clear = 1'b0;
  logic [15:0]                        job_count;

  int vecs = 0;
  int errs = 0;

  int   mock_n = 3;
  bit   mock_en = 1'b1;
  int   mcnt = 0;
  logic force_fin = 1'b0;

  always #5 clk = ~clk;

  mxu_operand_loader #(
    .DIM(DIM), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .elem_in(elem_in), .elem_valid(elem_valid),
    .elem_ready(elem_ready), .mxu_in0(mxu_in0), .mxu_in1(mxu_in1),
    .mxu_in_valid(mxu_in_valid), .mxu_finished(mxu_finished), .busy(busy),
    .timeout_err(timeout_err), .err_clear(err_clear), .job_count(job_count)
  );

  // Mock multiplier: finished high for one cycle, mock_n cycles after in_valid.
  always @(posedge clk) begin
    if (mxu_in_valid && mock_en) mcnt <= mock_n;
    else if (mcnt != 0) mcnt <= mcnt - 1;
  end
  assign mxu_finished = (mcnt == 1) || force_fin;

  task automatic push(input logic [7:0] v);
    @(negedge clk);
    elem_in    = v;
    elem_valid = 1'b1;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (elem_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    vecs++; if (elem_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %0h want 1", elem_ready); end
    vecs++; if (mxu_in_valid !== 1'b0) begin errs++; $display("FAIL rst_in_valid got %0h want 0", mxu_in_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %0h want 0", busy); end
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL rst_timeout got %0h want 0", timeout_err); end
    vecs++; if (job_count !== 16'd0) begin errs++; $display("FAIL rst_jobs got %0d want 0", job_count); end
    vecs++; if (mxu_in0 !== 32'h0) begin errs++; $display("FAIL rst_in0 got %h want 0", mxu_in0); end
    vecs++; if (mxu_in1 !== 32'h0) begin errs++; $display("FAIL rst_in1 got %h want 0", mxu_in1); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    bit ok;
    mock_en = 1'b1; mock_n = 3;
    for (int v = 1; v <= 8; v++) push(8'(v));
    vecs++; if (mxu_in_valid !== 1'b0) begin errs++; $display("FAIL stream_early_pulse got %0h want 0", mxu_in_valid); end
    @(negedge clk);
    elem_valid = 1'b0;
    vecs++; if (mxu_in_valid !== 1'b1) begin errs++; $display("FAIL stream_pulse got %0h want 1", mxu_in_valid); end
    vecs++; if (elem_ready !== 1'b0) begin errs++; $display("FAIL stream_issue_ready got %0h want 0", elem_ready); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL stream_busy got %0h want 1", busy); end
    @(negedge clk);
    vecs++; if (mxu_in_valid !== 1'b0) begin errs++; $display("FAIL stream_pulse_width got %0h want 0", mxu_in_valid); end
    vecs++; if (mxu_in0 !== 32'h04030201) begin errs++; $display("FAIL stream_A got %h want 04030201", mxu_in0); end
    vecs++; if (mxu_in0[0][1] !== 8'd2) begin errs++; $display("FAIL stream_A01 got %0d want 2", mxu_in0[0][1]); end
    vecs++; if (mxu_in1 !== 32'h08070605) begin errs++; $display("FAIL stream_B got %h want 08070605", mxu_in1); end
    wait_ready(40, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL stream_retire_timeout got %0h want 1", ok); end
    vecs++; if (job_count !== 16'd1) begin errs++; $display("FAIL stream_jobs got %0d want 1", job_count); end
  endtask

  task automatic test_bubbles();
    bit ok;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); elem_valid = 1'b1; elem_in = 8'(i + 1);
      @(negedge clk); elem_valid = 1'b0; elem_in = 8'hEE;
    end
    vecs++; if (mxu_in_valid !== 1'b1) begin errs++; $display("FAIL bubble_pulse got %0h want 1", mxu_in_valid); end
    vecs++; if (mxu_in0 !== 32'h04030201) begin errs++; $display("FAIL bubble_A got %h want 04030201", mxu_in0); end
    vecs++; if (mxu_in1 !== 32'h08070605) begin errs++; $display("FAIL bubble_B got %h want 08070605", mxu_in1); end
    wait_ready(40, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL bubble_retire_timeout got %0h want 1", ok); end
    vecs++; if (job_count !== 16'd2) begin errs++; $display("FAIL bubble_jobs got %0d want 2", job_count); end
  endtask

  task automatic test_wait_block();
    bit ok;
    bit prev_fin;
    int n;
    mock_n = 5;
    for (int v = 1; v <= 8; v++) push(8'(v));
    @(negedge clk);
    elem_in = 8'd9; elem_valid = 1'b1;
    vecs++; if (mxu_in_valid !== 1'b1) begin errs++; $display("FAIL wait_pulse got %0h want 1", mxu_in_valid); end
    ok = 1'b0; prev_fin = 1'b0; n = 0;
    while (n < 30) begin
      if (elem_ready) begin ok = 1'b1; break; end
      prev_fin = mxu_finished;
      @(negedge clk);
      n++;
    end
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL wait_ready_timeout got %0h want 1", ok); end
    vecs++; if (n !== 6) begin errs++; $display("FAIL wait_ready_latency got %0d want 6", n); end
    vecs++; if (prev_fin !== 1'b1) begin errs++; $display("FAIL wait_ready_after_fin got %0h want 1", prev_fin); end
    vecs++; if (job_count !== 16'd3) begin errs++; $display("FAIL wait_jobs got %0d want 3", job_count); end
    vecs++; if (mxu_in0 !== 32'h04030201) begin errs++; $display("FAIL wait_no_accept got %h want 04030201", mxu_in0); end
    for (int v = 10; v <= 16; v++) push(8'(v));
    @(negedge clk);
    elem_valid = 1'b0;
    vecs++; if (mxu_in_valid !== 1'b1) begin errs++; $display("FAIL wait2_pulse got %0h want 1", mxu_in_valid); end
    vecs++; if (mxu_in0 !== 32'h0C0B0A09) begin errs++; $display("FAIL wait2_A got %h want 0c0b0a09", mxu_in0); end
    vecs++; if (mxu_in1 !== 32'h100F0E0D) begin errs++; $display("FAIL wait2_B got %h want 100f0e0d", mxu_in1); end
    wait_ready(40, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL wait2_retire_timeout got %0h want 1", ok); end
    vecs++; if (job_count !== 16'd4) begin errs++; $display("FAIL wait2_jobs got %0d want 4", job_count); end
  endtask

  task automatic test_timeout();
    mock_en = 1'b0;
    for (int v = 1; v <= 8; v++) push(8'(v));
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) elem_valid = 1'b0;
    end
    vecs++; if (elem_ready !== 1'b0) begin errs++; $display("FAIL to_last_wait_ready got %0h want 0", elem_ready); end
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL to_early_err got %0h want 0", timeout_err); end
    @(negedge clk);
    vecs++; if (timeout_err !== 1'b1) begin errs++; $display("FAIL to_err got %0h want 1", timeout_err); end
    vecs++; if (elem_ready !== 1'b1) begin errs++; $display("FAIL to_back_to_load got %0h want 1", elem_ready); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL to_busy got %0h want 0", busy); end
    vecs++; if (job_count !== 16'd4) begin errs++; $display("FAIL to_jobs got %0d want 4", job_count); end
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL to_clear got %0h want 0", timeout_err); end
    force_fin = 1'b1;
    @(negedge clk);
    force_fin = 1'b0;
    @(negedge clk);
    vecs++; if (job_count !== 16'd4) begin errs++; $display("FAIL stray_fin_jobs got %0d want 4", job_count); end
    vecs++; if (elem_ready !== 1'b1) begin errs++; $display("FAIL stray_fin_ready got %0h want 1", elem_ready); end
    mock_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    mock_n = 3;
    push(8'hA1); push(8'hA2); push(8'hA3);
    @(negedge clk);
    elem_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    vecs++; if (mxu_in0 !== 32'h0) begin errs++; $display("FAIL rmid_in0 got %h want 0", mxu_in0); end
    vecs++; if (mxu_in1 !== 32'h0) begin errs++; $display("FAIL rmid_in1 got %h want 0", mxu_in1); end
    vecs++; if (job_count !== 16'd0) begin errs++; $display("FAIL rmid_jobs got %0d want 0", job_count); end
    vecs++; if ({mxu_in_valid, busy, timeout_err} !== 3'b000) begin errs++; $display("FAIL rmid_flags got %b want 000", {mxu_in_valid, busy, timeout_err}); end
    vecs++; if (elem_ready !== 1'b1) begin errs++; $display("FAIL rmid_ready got %0h want 1", elem_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int v = 8'h31; v <= 8'h38; v++) push(8'(v));
    @(negedge clk);
    elem_valid = 1'b0;
    vecs++; if (mxu_in_valid !== 1'b1) begin errs++; $display("FAIL rmid_pulse got %0h want 1", mxu_in_valid); end
    vecs++; if (mxu_in0 !== 32'h34333231) begin errs++; $display("FAIL rmid_A got %h want 34333231", mxu_in0); end
    vecs++; if (mxu_in1 !== 32'h38373635) begin errs++; $display("FAIL rmid_B got %h want 38373635", mxu_in1); end
    wait_ready(40, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL rmid_retire_timeout got %0h want 1", ok); end
    vecs++; if (job_count !== 16'd1) begin errs++; $display("FAIL rmid_jobs_after got %0d want 1", job_count); end
  endtask

  task automatic test_finish_boundary();
    mock_n = 16;
    for (int v = 8'h41; v <= 8'h48; v++) push(8'(v));
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) elem_valid = 1'b0;
    end
    vecs++; if (elem_ready !== 1'b0) begin errs++; $display("FAIL bnd_last_wait_ready got %0h want 0", elem_ready); end
    @(negedge clk);
    vecs++; if (elem_ready !== 1'b1) begin errs++; $display("FAIL bnd_ready got %0h want 1", elem_ready); end
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL bnd_err got %0h want 0", timeout_err); end
    vecs++; if (job_count !== 16'd2) begin errs++; $display("FAIL bnd_jobs got %0d want 2", job_count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bubbles();
    test_wait_block();
    test_timeout();
    test_reset_mid();
    test_finish_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit got expired want completion");
    $fatal(1, "time limit");
  end

endmodule
